// File: rtl/core_amo_pkg.sv
// Shared types for the atomic memory operation controller.
// Op encodings, FSM states and SC status codes.
package core_amo_pkg;

  typedef enum logic [3:0] {
    AMO_SWAP = 4'd0,
    AMO_ADD  = 4'd1,
    AMO_AND  = 4'd2,
    AMO_OR   = 4'd3,
    AMO_XOR  = 4'd4,
    AMO_MAX  = 4'd5,
    AMO_MIN  = 4'd6,
    AMO_MAXU = 4'd7,
    AMO_MINU = 4'd8,
    AMO_LR   = 4'd9,
    AMO_SC   = 4'd10
  } amo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RSP
  } amo_state_e;

  localparam logic SC_SUCCESS = 1'b0;
  localparam logic SC_FAIL    = 1'b1;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

endpackage

// File: rtl/core_amo_alu.sv
// Modify step of an AMO: combines old memory value with core operand.
// LR/SC fall through to the operand (SC writes it unchanged).
module core_amo_alu
  import core_amo_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  amo_op_e               i_op,
  output logic [DATA_WIDTH-1:0] o_res
);

  logic lt_s;
  logic lt_u;

  always_comb begin
    lt_s  = $signed(i_a) < $signed(i_b);
    lt_u  = i_a < i_b;
    o_res = i_b;
    case (i_op)
      AMO_SWAP: o_res = i_b;
      AMO_ADD:  o_res = i_a + i_b;
      AMO_AND:  o_res = i_a & i_b;
      AMO_OR:   o_res = i_a | i_b;
      AMO_XOR:  o_res = i_a ^ i_b;
      AMO_MAX:  o_res = lt_s ? i_b : i_a;
      AMO_MIN:  o_res = lt_s ? i_a : i_b;
      AMO_MAXU: o_res = lt_u ? i_b : i_a;
      AMO_MINU: o_res = lt_u ? i_a : i_b;
      default:  o_res = i_b;
    endcase
  end

endmodule

// File: rtl/core_amo_ctrl.sv
// Per-core AMO/LR/SC sequencer: read, modify, write on the memory port.
// Owns the single LR/SC reservation and returns old value or SC status.
module core_amo_ctrl
  import core_amo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int RESV_LSB   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [3:0]            i_req_amo_op,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_resv_inval,
  input  logic [ADDR_WIDTH-1:0] i_resv_inval_addr,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_busy
);

  localparam int LW = ADDR_WIDTH - RESV_LSB;

  amo_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [3:0]            op_q, op_d;
  logic                  err_q, err_d;
  logic                  sc_fail_q, sc_fail_d;
  logic                  resv_valid_q, resv_valid_d;
  logic [LW-1:0]         resv_line_q, resv_line_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [LW-1:0]         req_line, cur_line, inv_line;
  logic                  sc_ok;
  logic                  unused_lsbs;

  assign req_line = i_req_addr[ADDR_WIDTH-1:RESV_LSB];
  assign cur_line = addr_q[ADDR_WIDTH-1:RESV_LSB];
  assign inv_line = i_resv_inval_addr[ADDR_WIDTH-1:RESV_LSB];
  assign unused_lsbs = ^i_resv_inval_addr[RESV_LSB-1:0];

  // A snoop hitting the line in the accept cycle kills the SC
  assign sc_ok = resv_valid_q && (resv_line_q == req_line)
              && !(i_resv_inval && (resv_line_q == inv_line));

  // rdata feeds the ALU only into res_q, never straight to o_mem_wdata
  core_amo_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_a  (i_mem_rdata),
    .i_b  (wdata_q),
    .i_op (amo_op_e'(op_q)),
    .o_res(alu_res)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    res_d     = res_q;
    op_d      = op_q;
    err_d     = err_q;
    sc_fail_d = sc_fail_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          addr_d    = i_req_addr;
          wdata_d   = i_req_wdata;
          op_d      = i_req_amo_op;
          err_d     = 1'b0;
          sc_fail_d = 1'b0;
          if (!is_legal(i_req_amo_op)) begin
            err_d   = 1'b1;
            state_d = ST_RSP;
          end else if (i_req_amo_op == AMO_SC) begin
            sc_fail_d = !sc_ok;
            state_d   = sc_ok ? ST_WR_REQ : ST_RSP;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: if (i_mem_req_ready) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i_mem_rsp_valid) begin
          old_d   = i_mem_rdata;
          res_d   = alu_res;
          state_d = (op_q == AMO_LR) ? ST_RSP : ST_WR_REQ;
        end
      end
      ST_WR_REQ:  if (i_mem_req_ready) state_d = ST_WR_WAIT;
      ST_WR_WAIT: if (i_mem_rsp_valid) state_d = ST_RSP;
      ST_RSP:     if (i_rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_line_d  = resv_line_q;
    if (state_q == ST_IDLE && i_req_valid && i_req_amo_op == AMO_SC)
      resv_valid_d = 1'b0;
    if (state_q == ST_RD_WAIT && i_mem_rsp_valid && op_q == AMO_LR) begin
      resv_valid_d = 1'b1;
      resv_line_d  = cur_line;
    end
    if (state_q == ST_WR_REQ && i_mem_req_ready && op_q != AMO_SC
        && resv_line_q == cur_line)
      resv_valid_d = 1'b0;
    // Applied last so a snoop beats an LR setting the same line
    if (i_resv_inval && resv_line_d == inv_line)
      resv_valid_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      res_q        <= '0;
      op_q         <= '0;
      err_q        <= 1'b0;
      sc_fail_q    <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      res_q        <= res_d;
      op_q         <= op_d;
      err_q        <= err_d;
      sc_fail_q    <= sc_fail_d;
      resv_valid_q <= resv_valid_d;
      resv_line_q  <= resv_line_d;
    end
  end

  assign o_req_ready     = (state_q == ST_IDLE);
  assign o_busy          = (state_q != ST_IDLE);
  assign o_mem_req_valid = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign o_mem_we        = (state_q == ST_WR_REQ);
  assign o_mem_addr      = addr_q;
  assign o_rsp_valid     = (state_q == ST_RSP);
  assign o_rsp_err       = (state_q == ST_RSP) && err_q;

  always_comb begin
    o_mem_wdata = '0;
    if (state_q == ST_WR_REQ)
      o_mem_wdata = (op_q == AMO_SC) ? wdata_q : res_q;
  end

  always_comb begin
    o_rsp_data = '0;
    if (state_q == ST_RSP && !err_q) begin
      if (op_q == AMO_SC)
        o_rsp_data = {{(DATA_WIDTH-1){1'b0}},
                      sc_fail_q ? SC_FAIL : SC_SUCCESS};
      else
        o_rsp_data = old_q;
    end
  end

endmodule

// File: doc/core_amo_ctrl.md
Name: core_amo_ctrl

Overview:
Sequences atomic memory operations for one core. Accepts one AMO/LR/SC request at a time and runs it as read → ALU → write against the L1/bus memory port. Uses an instance of core_amo_alu for the modify step. Holds the single LR/SC reservation for the core and returns the old memory value, or the SC status, to the pipeline.

Parameters:
DATA_WIDTH, 64, data width of memory/core operands
ADDR_WIDTH, 64, byte address width
RESV_LSB, 3, low address bits ignored for the reservation match (log2(DATA_WIDTH/8))

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_req_valid  in  1  core request valid
o_req_ready  out  1  controller can accept; high only in IDLE
i_req_addr  in  ADDR_WIDTH  target address
i_req_wdata  in  DATA_WIDTH  core operand
i_req_amo_op  in  4  0000–1000 = ALU ops (SWAP, ADD, AND, OR, XOR, MAX, MIN, MAXU, MINU); 1001 = LR; 1010 = SC
o_mem_req_valid  out  1  memory request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_we  out  1  1 = write, 0 = read
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_wdata  out  DATA_WIDTH  write data
i_mem_rsp_valid  in  1  read data valid / write ack (one pulse per request)
i_mem_rdata  in  DATA_WIDTH  read data
i_resv_inval  in  1  snoop invalidate from coherence
i_resv_inval_addr  in  ADDR_WIDTH  snooped address
o_rsp_valid  out  1  result to core
i_rsp_ready  in  1  core accepts result
o_rsp_data  out  DATA_WIDTH  old memory value, or SC status (0 = success, 1 = fail)
o_rsp_err  out  1  illegal op
o_busy  out  1  state != IDLE

Behaviour:
- Reset (sync, i_rst=1 at a clock edge):
  - State goes to IDLE; reservation is cleared.
  - All valid outputs are 0, o_rsp_data/o_rsp_err are 0, o_req_ready=1.
  - A reset mid-operation abandons the operation. No write is issued.
  - i_mem_rsp_valid while in IDLE is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP.
- IDLE:
  - On i_req_valid && o_req_ready, latch addr, wdata and op.
  - Illegal op (1011–1111): go to RSP with data 0 and err=1. No memory access.
  - SC with no matching reservation: go to RSP with data 1. No memory access.
  - SC with a match: go to WR_REQ.
  - All other ops: go to RD_REQ.
- RD_REQ: o_mem_req_valid=1, we=0. Hold until i_mem_req_ready, then go to RD_WAIT.
- RD_WAIT: on i_mem_rsp_valid, latch rdata into old_q.
  - LR: set the reservation {valid, addr}, then go to RSP.
  - ALU op: go to WR_REQ.
- WR_REQ: o_mem_req_valid=1, we=1.
  - wdata = registered ALU result for AMOs (core_amo_alu(old_q, wdata_q, op_q)); wdata_q for SC.
  - Hold until i_mem_req_ready, then go to WR_WAIT.
- WR_WAIT: on i_mem_rsp_valid, go to RSP.
- RSP: o_rsp_valid=1.
  - o_rsp_data = old_q for AMO/LR; 0 for a successful SC.
  - Hold until i_rsp_ready, then go to IDLE.
- Mem request outputs are stable while o_mem_req_valid=1 && !i_mem_req_ready. Same rule for the response outputs.
- Memory response arrives no earlier than the cycle after the request handshake.
- Latency with a zero-wait memory (ready=1, response one cycle later), request accepted in cycle 0:
  - AMO: o_rsp_valid in cycle 5.
  - LR: o_rsp_valid in cycle 3.
  - SC success: o_rsp_valid in cycle 3.
  - SC fail / illegal: o_rsp_valid in cycle 1.
- Reservation match: valid && resv_addr[ADDR_WIDTH-1:RESV_LSB] == addr[ADDR_WIDTH-1:RESV_LSB].
- Reservation clear events:
  - Any SC, at IDLE accept, success or fail.
  - i_resv_inval with a matching address, in any state.
  - An AMO write handshake to a matching address.
- Simultaneous events:
  - Invalidate in the same cycle the LR sets the reservation: invalidate wins, reservation stays clear.
  - Invalidate in the same cycle an SC is accepted: the SC fails.
- ALU result is registered in the RD_WAIT→WR_REQ transition, so the write path has no combinational path from i_mem_rdata to o_mem_wdata.

Decomposition:
- Shared package core_amo_pkg holds:
  - amo_op_e enum (the 11 encodings above);
  - amo_state_e FSM enum;
  - constants SC_SUCCESS=0 and SC_FAIL=1.
- core_amo_alu is reused as the single sub-module; it should also import amo_op_e.
- Reservation logic stays inline (about 20 lines).

Test Plan:
- AMOADD, mem[0x100]=5, wdata=3, zero-wait memory → read 0x100, then write 8 to 0x100; o_rsp_data=5 in cycle 5; o_busy low in cycle 6.
- AMOMIN (0110), mem=0xFFFF_FFFF_FFFF_FFFE (−2), wdata=1 → write −2; rsp=−2. AMOMINU (1000) with the same values → write 1.
- LR 0x200 (mem=0xAA), then SC 0x204 wdata=0x55 → write 0x55 to 0x204; rsp 0. A second SC 0x200 → rsp 1, no memory request.
- LR 0x200, then i_resv_inval_addr=0x200 pulse, then SC 0x200 → rsp 1, no write. Repeat with the invalidate in the same cycle LR rdata returns → SC fails.
- i_mem_req_ready held low 4 cycles and i_rsp_ready low 3 cycles → request and response outputs stable throughout, with a single write issued.
- i_rst asserted in WR_REQ → next cycle IDLE, o_mem_req_valid=0, reservation clear. A stray i_mem_rsp_valid afterwards is ignored. op=1111 → rsp data 0, err=1 in cycle 1.
